// File: rtl/adc_cap_pkg.sv
// Shared encodings and width helpers for the triggered ADC capture buffer.
package adc_cap_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO       = 2'b00,
        MODE_NORMAL     = 2'b01,
        MODE_SINGLE     = 2'b10,
        MODE_NORMAL_ALT = 2'b11
    } mode_e;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRE_FILL  = 3'd1;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
    localparam logic [2:0] ST_POST_FILL = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // A single channel still needs a 1-bit select port.
    function automatic int cw_of(input int ch_num);
        return (ch_num > 1) ? clog2(ch_num) : 1;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one word holds every channel's sample for one
// time slot, so all channels are written together; the read port selects a lane.
module capture_ram #(
    parameter int DW     = 8,
    parameter int CH_NUM = 2,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10,
    parameter int CW     = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 we,
    input  logic [AW-1:0]        wr_addr,
    input  logic [CH_NUM*DW-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [CW-1:0]        rd_ch,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data
);

    logic [CH_NUM*DW-1:0] mem [DEPTH];
    logic [CH_NUM*DW-1:0] rd_word;
    logic [CW-1:0]        rd_ch_q;

    // NOTE: the storage array is deliberately never reset so it maps onto block RAM;
    // only the output register is cleared.
    always_ff @(posedge sys_clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_word <= '0;
            rd_ch_q <= '0;
        end else if (rd_en) begin
            rd_word <= mem[rd_addr];
            rd_ch_q <= rd_ch;
        end
    end

    // NOTE: a default assignment before the selection loop keeps this purely combinational.
    always_comb begin
        rd_data = rd_word[DW-1:0];
        for (int c = 1; c < CH_NUM; c++)
            if (rd_ch_q == c[CW-1:0]) rd_data = rd_word[c*DW +: DW];
    end

endmodule

// File: rtl/adc_trig_capture.sv
// Multi-channel triggered capture buffer: circular per-channel store with a
// programmable pre-trigger depth, edge/auto triggering and a frozen read window.
module adc_trig_capture
    import adc_cap_pkg::*;
#(
    parameter int  CH_NUM  = 2,
    parameter int  DW      = 8,
    parameter int  DEPTH   = 1024,
    parameter int  PRE     = 256,
    parameter int  AUTO_TO = 50_000_000,
    localparam int CW      = cw_of(CH_NUM),
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 ad_valid,
    input  logic [CH_NUM*DW-1:0] ad_data,
    input  logic [1:0]           mode,
    input  logic [CW-1:0]        trig_ch,
    input  logic [DW-1:0]        trig_level,
    input  logic                 trig_edge,
    input  logic                 arm,
    input  logic                 rd_en,
    input  logic [CW-1:0]        rd_ch,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_valid,
    output logic                 frame_rdy,
    output logic                 triggered,
    output logic                 busy
);

    localparam int TW = clog2(AUTO_TO + 1);

    logic [2:0]    state, st_eff;
    logic [AW-1:0] wr_ptr, trig_addr, cnt, cnt_eff, rd_phys;
    logic [TW-1:0] to_cnt;
    logic [DW-1:0] prev, cur;
    logic          edge_hit, force_trig, we;

    always_comb begin
        cur = ad_data[DW-1:0];
        for (int c = 1; c < CH_NUM; c++)
            if (trig_ch == c[CW-1:0]) cur = ad_data[c*DW +: DW];
    end

    assign edge_hit   = trig_edge ? (prev > trig_level && cur <= trig_level)
                                  : (prev < trig_level && cur >= trig_level);
    assign force_trig = (mode == MODE_AUTO) && (to_cnt == TW'(AUTO_TO));

    // An arm is resolved before the sample of the same cycle is considered.
    always_comb begin
        st_eff = state;
        if (arm) st_eff = (state == ST_DONE && mode == MODE_SINGLE) ? ST_IDLE : ST_PRE_FILL;
    end

    assign cnt_eff = arm ? '0 : cnt;
    assign we      = ad_valid && (st_eff inside {ST_PRE_FILL, ST_WAIT_TRIG, ST_POST_FILL});
    assign busy    = state inside {ST_PRE_FILL, ST_WAIT_TRIG, ST_POST_FILL};
    assign rd_phys = trig_addr - AW'(PRE) + rd_addr;

    // NOTE: sequential state uses non-blocking assignments only; a later assignment
    // in this block intentionally overrides an earlier default.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            trig_addr <= '0;
            cnt       <= '0;
            to_cnt    <= '0;
            prev      <= '0;
            frame_rdy <= 1'b0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            state    <= st_eff;
            cnt      <= cnt_eff;
            if (ad_valid) prev <= cur;
            if (we) wr_ptr <= wr_ptr + AW'(1);

            if (arm || state != ST_WAIT_TRIG) to_cnt <= '0;
            else if (to_cnt != TW'(AUTO_TO))  to_cnt <= to_cnt + TW'(1);

            if (arm) begin
                frame_rdy <= 1'b0;
                triggered <= 1'b0;
            end

            if (ad_valid) begin
                case (st_eff)
                    ST_PRE_FILL: begin
                        if (cnt_eff == AW'(PRE - 1)) begin
                            state <= ST_WAIT_TRIG;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_eff + AW'(1);
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (edge_hit || force_trig) begin
                            trig_addr <= wr_ptr;
                            triggered <= edge_hit;
                            state     <= ST_POST_FILL;
                        end
                    end
                    ST_POST_FILL: begin
                        if (cnt_eff == AW'(DEPTH - PRE - 2)) begin
                            state     <= ST_DONE;
                            frame_rdy <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt_eff + AW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    capture_ram #(
        .DW    (DW),
        .CH_NUM(CH_NUM),
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) u_ram (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .we     (we),
        .wr_addr(wr_ptr),
        .wr_data(ad_data),
        .rd_en  (rd_en),
        .rd_ch  (rd_ch),
        .rd_addr(rd_phys),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed bench for adc_trig_capture: reads are scoreboarded through a queue
// checked by an independent monitor; control outputs are checked inline.
module tb_adc_trig_capture;
    import adc_cap_pkg::*;

    localparam int CH_NUM = 2, DW = 8, DEPTH = 16, PRE = 4, AUTO_TO = 100;

    logic        sys_clk = 1'b0, sys_rst = 1'b1, ad_valid = 1'b0;
    logic [15:0] ad_data = '0;
    logic [1:0]  mode = MODE_NORMAL;
    logic        trig_ch = 1'b0, trig_edge = 1'b0, arm = 1'b0, rd_en = 1'b0, rd_ch = 1'b0;
    logic [7:0]  trig_level = 8'h80;
    logic [3:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_valid, frame_rdy, triggered, busy;

    typedef struct {
        logic [7:0] data;
        string      tag;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int n_vec = 0, n_err = 0;

    logic [7:0] seq_a [7] = '{8'h70, 8'h90, 8'h91, 8'h92, 8'h70, 8'h60, 8'h94};
    logic [7:0] seq_b [6] = '{8'h70, 8'h90, 8'h95, 8'h96, 8'h20, 8'h88};
    logic [7:0] seq_c [4] = '{8'h55, 8'h60, 8'h70, 8'h78};

    always #5 sys_clk = ~sys_clk;

    adc_trig_capture #(
        .CH_NUM(CH_NUM), .DW(DW), .DEPTH(DEPTH), .PRE(PRE), .AUTO_TO(AUTO_TO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ad_valid(ad_valid), .ad_data(ad_data),
        .mode(mode), .trig_ch(trig_ch), .trig_level(trig_level), .trig_edge(trig_edge),
        .arm(arm), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .frame_rdy(frame_rdy), .triggered(triggered), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got rd_data 0x%0h, expected no read response", rd_data);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check(e.tag, 32'(rd_data), 32'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // One sample per two cycles: strobe high for a cycle, then low for a cycle.
    task automatic put_sample(input logic [7:0] c0, input logic [7:0] c1, input logic with_arm);
        ad_valid = 1'b1;
        ad_data  = {c1, c0};
        arm      = with_arm;
        step();
        ad_valid = 1'b0;
        arm      = 1'b0;
        step();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic rd(input logic ch, input logic [3:0] addr, input logic [7:0] exp, input string name);
        rd_en   = 1'b1;
        rd_ch   = ch;
        rd_addr = addr;
        exp_q.push_back('{data: exp, tag: $sformatf("%s_ch%0d_a%0d", name, ch, addr)});
        step();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        step();
        step();
    endtask

    initial begin
        int   n;
        logic seen;

        step();
        step();
        sys_rst = 1'b0;
        check("rst_frame_rdy", 32'(frame_rdy), 0);
        check("rst_triggered", 32'(triggered), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);

        // Reset while in POST_FILL
        pulse_arm();
        for (int k = 0; k < 20; k++) put_sample(8'(8 * k), 8'h00, 1'b0);
        check("t1_busy_in_post", 32'(busy), 1);
        check("t1_not_done_yet", 32'(frame_rdy), 0);
        sys_rst = 1'b1;
        rd_en   = 1'b1;
        step();
        sys_rst = 1'b0;
        rd_en   = 1'b0;
        check("t1_frame_rdy_after_rst", 32'(frame_rdy), 0);
        check("t1_busy_after_rst", 32'(busy), 0);
        check("t1_rd_valid_after_rst", 32'(rd_valid), 0);
        put_sample(8'h90, 8'h90, 1'b0);
        put_sample(8'hA0, 8'hA0, 1'b0);
        check("t1_idle_ignores_samples", 32'(busy), 0);

        // Rising ramp on ch0, normal mode
        pulse_arm();
        check("t2_busy_after_arm", 32'(busy), 1);
        for (int k = 0; k < 28; k++) begin
            if (k == 27) check("t2_not_done_before_last", 32'(frame_rdy), 0);
            put_sample(8'(8 * k), 8'(255 - 8 * k), 1'b0);
        end
        check("t2_frame_rdy", 32'(frame_rdy), 1);
        check("t2_triggered", 32'(triggered), 1);
        check("t2_busy_done", 32'(busy), 0);
        rd(1'b0, 4'd4, 8'h80, "t2");
        rd(1'b0, 4'd3, 8'h78, "t2");
        rd(1'b0, 4'd15, 8'hD8, "t2");
        rd(1'b0, 4'd0, 8'h60, "t2");
        rd(1'b1, 4'd4, 8'h7F, "t2");
        drain();

        // Falling ramp on ch1, ch0 constant
        trig_ch   = 1'b1;
        trig_edge = 1'b1;
        pulse_arm();
        check("t3_frame_rdy_drops", 32'(frame_rdy), 0);
        for (int k = 0; k < 19; k++) put_sample(8'h33, 8'(240 - 16 * k), 1'b0);
        check("t3_frame_rdy", 32'(frame_rdy), 1);
        check("t3_triggered", 32'(triggered), 1);
        rd(1'b1, 4'd4, 8'h80, "t3");
        rd(1'b1, 4'd0, 8'hC0, "t3");
        rd(1'b1, 4'd15, 8'hD0, "t3");
        for (int a = 0; a < 16; a++) rd(1'b0, 4'(a), 8'h33, "t3_const");
        drain();

        // Auto timeout with a flat signal
        trig_ch   = 1'b0;
        trig_edge = 1'b0;
        mode      = MODE_AUTO;
        pulse_arm();
        n = 0;
        while (!frame_rdy && n < 80) begin
            put_sample(8'h10, 8'h10, 1'b0);
            n++;
        end
        check("t4_auto_completes", 32'(frame_rdy), 1);
        check("t4_auto_sample_count_in_window", 32'(n >= 62 && n <= 70), 1);
        check("t4_auto_triggered", 32'(triggered), 0);
        rd(1'b0, 4'd4, 8'h10, "t4");
        drain();

        // Normal mode never completes on a flat signal
        mode = MODE_NORMAL;
        pulse_arm();
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            put_sample(8'h10, 8'h10, 1'b0);
            seen = seen | frame_rdy;
        end
        check("t4_normal_no_frame", 32'(seen), 0);
        check("t4_normal_still_busy", 32'(busy), 1);

        // Single mode
        mode = MODE_SINGLE;
        pulse_arm();
        for (int k = 0; k < 28; k++) put_sample(8'(8 * k), 8'h00, 1'b0);
        check("t5_frame_rdy", 32'(frame_rdy), 1);
        check("t5_triggered", 32'(triggered), 1);
        put_sample(8'hEE, 8'hEE, 1'b1);
        check("t5_rearm_frame_rdy", 32'(frame_rdy), 0);
        check("t5_rearm_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) put_sample(8'hEE, 8'hEE, 1'b0);
        check("t5_idle_busy", 32'(busy), 0);
        rd(1'b0, 4'd0, 8'h60, "t5_no_write");
        rd(1'b0, 4'd15, 8'hD8, "t5_no_write");
        drain();
        pulse_arm();
        check("t5_second_arm_busy", 32'(busy), 1);
        for (int k = 0; k < 28; k++) put_sample(8'(4 + 8 * k), 8'h00, 1'b0);
        check("t5_second_frame_rdy", 32'(frame_rdy), 1);
        check("t5_second_triggered", 32'(triggered), 1);
        rd(1'b0, 4'd4, 8'h84, "t5b");
        rd(1'b0, 4'd3, 8'h7C, "t5b");
        drain();

        // Crossing during PRE_FILL is ignored
        mode = MODE_NORMAL;
        pulse_arm();
        for (int i = 0; i < 7; i++) put_sample(seq_a[i], 8'h00, 1'b0);
        for (int j = 0; j < 11; j++) begin
            if (j == 10) check("t6a_not_done_before_last", 32'(frame_rdy), 0);
            put_sample(8'(160 + j), 8'h00, 1'b0);
        end
        check("t6a_frame_rdy", 32'(frame_rdy), 1);
        rd(1'b0, 4'd4, 8'h94, "t6a");
        rd(1'b0, 4'd3, 8'h60, "t6a");
        rd(1'b0, 4'd0, 8'h91, "t6a");
        drain();

        // Arm while waiting for a trigger restarts the pre-fill
        pulse_arm();
        for (int i = 0; i < 5; i++) put_sample(8'(16 * (i + 1)), 8'h00, 1'b0);
        pulse_arm();
        check("t6b_busy_after_rearm", 32'(busy), 1);
        for (int i = 0; i < 6; i++) put_sample(seq_b[i], 8'h00, 1'b0);
        for (int j = 0; j < 11; j++) put_sample(8'(176 + j), 8'h00, 1'b0);
        check("t6b_frame_rdy", 32'(frame_rdy), 1);
        rd(1'b0, 4'd4, 8'h88, "t6b");
        rd(1'b0, 4'd3, 8'h20, "t6b");
        rd(1'b0, 4'd0, 8'h90, "t6b");
        drain();

        // Sample coincident with arm becomes pre-fill sample 0
        put_sample(seq_c[0], 8'h00, 1'b1);
        check("t6c_frame_rdy_drops", 32'(frame_rdy), 0);
        check("t6c_busy", 32'(busy), 1);
        for (int i = 1; i < 4; i++) put_sample(seq_c[i], 8'h00, 1'b0);
        put_sample(8'h85, 8'h00, 1'b0);
        for (int j = 0; j < 11; j++) put_sample(8'(192 + j), 8'h00, 1'b0);
        check("t6c_frame_rdy", 32'(frame_rdy), 1);
        rd(1'b0, 4'd0, 8'h55, "t6c");
        rd(1'b0, 4'd1, 8'h60, "t6c");
        rd(1'b0, 4'd4, 8'h85, "t6c");
        drain();

        check("rd_queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish within 2 ms");
        $fatal(1);
    end

endmodule
